exe_stage: RTL and testbench
============================

EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 Parameters: none; all widths SHALL be fixed as listed.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 resetn  in  1  reset, asynchronous, active-low.
REQ-004 ds_to_es_valid  in  1  ID payload valid.
REQ-005 es_allowin  out  1  stage can accept ID payload.
REQ-006 ds_pc  in  32  instruction PC.
REQ-007 ds_alu_op  in  3  000 add, 001 sub, 010 slt, 011 sltu, 100 and, 101 or, 110 xor, 111 pass src2.
REQ-008 ds_src1, ds_src2  in  32 each  ALU operands; memory address = src1+src2.
REQ-009 ds_mem_op  in  8  one-hot or zero {ld_w, ld_h, ld_hu, ld_b, ld_bu, st_w, st_h, st_b}.
REQ-010 ds_st_data  in  32  store data.
REQ-011 ds_rf_we  in  1 / ds_rf_waddr  in  5  register write.
REQ-012 ds_except  in  7  upstream exception bits; bit 6 is reserved zero.
REQ-013 ms_allowin  in  1  MEM stage can accept.
REQ-014 es_to_ms_valid  out  1 / es_pc  out  32.
REQ-015 es_rf_collect  out  39  {res_from_mem, rf_we, rf_waddr, result}.
REQ-016 mem_inst_bus  out  5  {ld_w, ld_h, ld_hu, ld_b, ld_bu}.
REQ-017 es_to_ms_bus  out  8  {wait_data_ok, except[6:0]}.
REQ-018 data_sram_req/wr  out  1 each; size  out  2; wstrb  out  4; addr/wdata  out  32 each; data_sram_addr_ok  in  1.
REQ-019 except_flush, ms_ex, wb_ex  in  1 each  flush / exception held in MEM / exception held in WB.

Function
REQ-020 es_valid SHALL clear on except_flush; otherwise it SHALL load ds_to_es_valid when es_allowin.
REQ-021 Payload SHALL register only on ds_to_es_valid & es_allowin.
REQ-022 result SHALL be the 32-bit wrapped ALU output; slt signed, sltu unsigned, 1/0 zero-extended.
REQ-023 ALE (except bit 6) SHALL set when the half op has addr[0]=1 or the word op has addr[1:0]!=0; except = ds_except | {ALE,6'b0}.
REQ-024 es_cancel = |except | ms_ex | wb_ex | except_flush.
REQ-025 FSM states IDLE, REQ, SENT. IDLE->REQ: es_valid & mem op & ~es_cancel & ~addr_ok. IDLE->SENT or REQ->SENT: req & addr_ok.
REQ-026 SENT->IDLE on es_to_ms_valid & ms_allowin. Any state->IDLE on except_flush.
REQ-027 data_sram_req SHALL be 1 in REQ, and in IDLE when es_valid & mem op & ~es_cancel; it SHALL be 0 in SENT.
REQ-028 In REQ, req and all request fields SHALL stay stable until addr_ok; ms_ex/wb_ex SHALL NOT withdraw the request; only except_flush SHALL withdraw it.
REQ-029 size: word 2, half 1, byte 0. wr = store op.
REQ-030 wstrb: st_w 1111; st_h addr[1] ? 1100 : 0011; st_b 0001<<addr[1:0]; loads 0000.
REQ-031 wdata: st_b {4{data[7:0]}}; st_h {2{data[15:0]}}; st_w data.
REQ-032 es_ready_go = ~mem op | (cancelled in IDLE) | SENT | (req & addr_ok).
REQ-033 es_allowin = ~es_valid | es_ready_go & ms_allowin; es_to_ms_valid = es_valid & es_ready_go.
REQ-034 wait_data_ok SHALL be 1 iff a request handshook for this instruction, i.e. SENT or same-cycle req & addr_ok.
REQ-035 res_from_mem SHALL equal any load op; mem_inst_bus SHALL be the load bits of ds_mem_op.
REQ-036 A store with es_cancel SHALL never issue req.

Reset
REQ-037 resetn low SHALL immediately set es_valid 0, FSM IDLE and payload 0, independent of clk.
REQ-038 During reset, es_to_ms_valid, req and all bus outputs SHALL be 0 and es_allowin SHALL be 1.
REQ-039 Reset asserted while in REQ or SENT SHALL return to IDLE with no req on the next edge.

Verification
REQ-040 add 5+7, no mem op -> result 12, es_to_ms_valid 1 cycle after accept, wait_data_ok 0.
REQ-041 st_b addr 0x1003, data 0xAB, addr_ok low 3 cycles -> req held 4 cycles with addr 0x1003, wstrb 1000, wdata 0xABABABAB stable; then passes with wait_data_ok 1.
REQ-042 ld_h addr 0x2001 -> no req; except[6]=1; passes with wait_data_ok 0.
REQ-043 st_w with wb_ex=1 in IDLE -> no req. Then ms_allowin=0 after a load's addr_ok -> SENT held, no second req.
REQ-044 except_flush in REQ -> req 0 next cycle, es_valid 0, FSM IDLE; slt -1,1 -> 1; sltu -1,1 -> 0.
REQ-045 resetn low mid-REQ -> outputs 0 asynchronously; after release, es_allowin 1 and no req.

Source files
------------

// File: rtl/exe_stage_if.sv
// ----------------------------------------------------------------------------
// exe_stage_if -- data SRAM request channel between the EXE stage and memory.
//
//   data_sram_req      EXE -> MEM  request valid
//   data_sram_wr       EXE -> MEM  1 = store, 0 = load
//   data_sram_size     EXE -> MEM  0 byte, 1 half, 2 word
//   data_sram_wstrb    EXE -> MEM  byte lane enables (stores only)
//   data_sram_addr     EXE -> MEM  byte address
//   data_sram_wdata    EXE -> MEM  lane-replicated store data
//   data_sram_addr_ok  MEM -> EXE  request accepted this cycle
// ----------------------------------------------------------------------------
interface exe_stage_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok
  );
endinterface

// File: rtl/exe_stage.sv
// ----------------------------------------------------------------------------
// exe_stage -- pipeline EXE stage: ALU, address generation, alignment check
// and data SRAM request issue with a request/handshake FSM.
//
// Ports
//   clk, resetn                 clock, async active-low reset
//   ds_to_es_valid/es_allowin   ID -> EXE handshake
//   ds_*                        ID payload (pc, alu op, operands, mem op,
//                               store data, reg write, exceptions)
//   ms_allowin                  MEM stage can accept
//   es_to_ms_valid, es_pc       EXE -> MEM valid and PC
//   es_rf_collect               {res_from_mem, rf_we, rf_waddr, result}
//   mem_inst_bus                {ld_w, ld_h, ld_hu, ld_b, ld_bu}
//   es_to_ms_bus                {wait_data_ok, except[6:0]}
//   except_flush, ms_ex, wb_ex  flush / exception pending downstream
//   dmem                        data SRAM request channel (master side)
// ----------------------------------------------------------------------------
module exe_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ds_to_es_valid,
  output logic        es_allowin,
  input  logic [31:0] ds_pc,
  input  logic [2:0]  ds_alu_op,
  input  logic [31:0] ds_src1,
  input  logic [31:0] ds_src2,
  input  logic [7:0]  ds_mem_op,
  input  logic [31:0] ds_st_data,
  input  logic        ds_rf_we,
  input  logic [4:0]  ds_rf_waddr,
  input  logic [6:0]  ds_except,
  input  logic        ms_allowin,
  output logic        es_to_ms_valid,
  output logic [31:0] es_pc,
  output logic [38:0] es_rf_collect,
  output logic [4:0]  mem_inst_bus,
  output logic [7:0]  es_to_ms_bus,
  input  logic        except_flush,
  input  logic        ms_ex,
  input  logic        wb_ex,
  exe_stage_if.master dmem
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // no request outstanding
    S_REQ  = 2'd1,  // request raised, waiting for addr_ok
    S_SENT = 2'd2   // request accepted, waiting to move to MEM
  } state_e;

  state_e      state_q, state_d;
  logic        es_valid_q;
  logic [31:0] pc_q, src1_q, src2_q, st_data_q;
  logic [2:0]  alu_op_q;
  logic [7:0]  mem_op_q;
  logic        rf_we_q;
  logic [4:0]  rf_waddr_q;
  logic [6:0]  except_q;

  // Mem-op decode; bit order {ld_w, ld_h, ld_hu, ld_b, ld_bu, st_w, st_h, st_b}
  logic ld_w, ld_h, ld_hu, st_w, st_h, st_b;
  logic is_load, is_store, is_mem, op_word, op_half;
  assign ld_w     = mem_op_q[7];
  assign ld_h     = mem_op_q[6];
  assign ld_hu    = mem_op_q[5];
  assign st_w     = mem_op_q[2];
  assign st_h     = mem_op_q[1];
  assign st_b     = mem_op_q[0];
  assign is_load  = |mem_op_q[7:3];
  assign is_store = |mem_op_q[2:0];
  assign is_mem   = is_load | is_store;
  assign op_word  = ld_w | st_w;
  assign op_half  = ld_h | ld_hu | st_h;

  logic [31:0] mem_addr;
  logic        ale;
  logic [6:0]  es_except;
  logic        es_cancel;
  assign mem_addr  = src1_q + src2_q;
  assign ale       = (op_half & mem_addr[0]) | (op_word & (|mem_addr[1:0]));
  assign es_except = except_q | {ale, 6'b0};
  assign es_cancel = (|es_except) | ms_ex | wb_ex | except_flush;

  // ALU
  logic [31:0] alu_result;
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    alu_result = 32'd0;
    case (alu_op_q)
      3'd0: alu_result = mem_addr;
      3'd1: alu_result = src1_q - src2_q;
      3'd2: alu_result = {31'd0, $signed(src1_q) < $signed(src2_q)};
      3'd3: alu_result = {31'd0, src1_q < src2_q};
      3'd4: alu_result = src1_q & src2_q;
      3'd5: alu_result = src1_q | src2_q;
      3'd6: alu_result = src1_q ^ src2_q;
      3'd7: alu_result = src2_q;
    endcase
  end

  // Request FSM. In REQ the request is held regardless of ms_ex/wb_ex so the
  // memory side never sees a withdrawn request; only a flush drops it.
  logic sram_req, handshake, es_ready_go, es_leave;
  always_comb begin
    state_d  = state_q;
    sram_req = 1'b0;
    case (state_q)
      S_IDLE:  sram_req = es_valid_q & is_mem & ~es_cancel;
      S_REQ:   sram_req = 1'b1;
      default: sram_req = 1'b0;
    endcase

    handshake   = sram_req & dmem.data_sram_addr_ok;
    es_ready_go = ~is_mem | ((state_q == S_IDLE) & es_cancel) |
                  (state_q == S_SENT) | handshake;
    es_leave    = es_valid_q & es_ready_go & ms_allowin;

    case (state_q)
      S_IDLE: begin
        // Skip SENT when the instruction moves on in the handshake cycle.
        if (handshake)     state_d = es_leave ? S_IDLE : S_SENT;
        else if (sram_req) state_d = S_REQ;
      end
      S_REQ:   if (handshake) state_d = es_leave ? S_IDLE : S_SENT;
      S_SENT:  if (es_leave)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (except_flush) state_d = S_IDLE;
  end

  assign es_allowin     = ~es_valid_q | (es_ready_go & ms_allowin);
  assign es_to_ms_valid = es_valid_q & es_ready_go;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      es_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (except_flush)    es_valid_q <= 1'b0;
      else if (es_allowin) es_valid_q <= ds_to_es_valid;
    end
  end

  // NOTE: payload registers are reset as well, so every output bus reads
  // zero while resetn is low instead of leaking stale operands.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q       <= 32'd0;
      alu_op_q   <= 3'd0;
      src1_q     <= 32'd0;
      src2_q     <= 32'd0;
      mem_op_q   <= 8'd0;
      st_data_q  <= 32'd0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      except_q   <= 7'd0;
    end else if (ds_to_es_valid && es_allowin) begin
      pc_q       <= ds_pc;
      alu_op_q   <= ds_alu_op;
      src1_q     <= ds_src1;
      src2_q     <= ds_src2;
      mem_op_q   <= ds_mem_op;
      st_data_q  <= ds_st_data;
      rf_we_q    <= ds_rf_we;
      rf_waddr_q <= ds_rf_waddr;
      except_q   <= ds_except;
    end
  end

  // Store byte lanes and lane-replicated write data
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  always_comb begin
    wstrb = 4'b0000;
    if (st_w)      wstrb = 4'b1111;
    else if (st_h) wstrb = mem_addr[1] ? 4'b1100 : 4'b0011;
    else if (st_b) wstrb = 4'b0001 << mem_addr[1:0];
  end
  assign wdata = st_b ? {4{st_data_q[7:0]}}  :
                 st_h ? {2{st_data_q[15:0]}} : st_data_q;

  assign dmem.data_sram_req   = sram_req;
  assign dmem.data_sram_wr    = is_store;
  assign dmem.data_sram_size  = op_word ? 2'd2 : (op_half ? 2'd1 : 2'd0);
  assign dmem.data_sram_wstrb = wstrb;
  assign dmem.data_sram_addr  = mem_addr;
  assign dmem.data_sram_wdata = wdata;

  assign es_pc         = pc_q;
  assign es_rf_collect = {is_load, rf_we_q, rf_waddr_q, alu_result};
  assign mem_inst_bus  = mem_op_q[7:3];
  // wait_data_ok: a request was accepted for this instruction
  assign es_to_ms_bus  = {(state_q == S_SENT) | handshake, es_except};

endmodule

// File: tb/tb_exe_stage.sv
// ----------------------------------------------------------------------------
// tb_exe_stage -- scoreboard bench for exe_stage. Stimulus pushes expected
// MEM-side outputs and expected SRAM requests; a monitor pops and compares
// whenever the DUT hands an instruction to MEM or presents a request.
// ----------------------------------------------------------------------------
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ds_to_es_valid = 1'b0;
  logic        es_allowin;
  logic [31:0] ds_pc = '0, ds_src1 = '0, ds_src2 = '0, ds_st_data = '0;
  logic [2:0]  ds_alu_op = '0;
  logic [7:0]  ds_mem_op = '0;
  logic        ds_rf_we = 1'b0;
  logic [4:0]  ds_rf_waddr = '0;
  logic [6:0]  ds_except = '0;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [31:0] es_pc;
  logic [38:0] es_rf_collect;
  logic [4:0]  mem_inst_bus;
  logic [7:0]  es_to_ms_bus;
  logic        except_flush = 1'b0, ms_ex = 1'b0, wb_ex = 1'b0;

  // Directed vs random drive of the two downstream-ready inputs
  logic rnd_en = 1'b0;
  logic rnd_addr_ok = 1'b0, rnd_ms = 1'b1;
  logic dir_addr_ok = 1'b1, dir_ms = 1'b1;

  exe_stage_if dmem ();
  assign dmem.data_sram_addr_ok = rnd_en ? rnd_addr_ok : dir_addr_ok;
  assign ms_allowin             = rnd_en ? rnd_ms      : dir_ms;

  exe_stage dut (
    .clk(clk), .resetn(resetn),
    .ds_to_es_valid(ds_to_es_valid), .es_allowin(es_allowin),
    .ds_pc(ds_pc), .ds_alu_op(ds_alu_op), .ds_src1(ds_src1), .ds_src2(ds_src2),
    .ds_mem_op(ds_mem_op), .ds_st_data(ds_st_data), .ds_rf_we(ds_rf_we),
    .ds_rf_waddr(ds_rf_waddr), .ds_except(ds_except), .ms_allowin(ms_allowin),
    .es_to_ms_valid(es_to_ms_valid), .es_pc(es_pc), .es_rf_collect(es_rf_collect),
    .mem_inst_bus(mem_inst_bus), .es_to_ms_bus(es_to_ms_bus),
    .except_flush(except_flush), .ms_ex(ms_ex), .wb_ex(wb_ex), .dmem(dmem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc; logic [2:0] op; logic [31:0] a, b; logic [7:0] mop;
    logic [31:0] sd; logic we; logic [4:0] wa; logic [6:0] exc;
  } in_t;
  typedef struct {
    logic [31:0] pc; logic [38:0] collect; logic [4:0] minst; logic [7:0] bus;
  } out_t;
  typedef struct {
    logic wr; logic [1:0] size; logic [3:0] wstrb; logic [31:0] addr, wdata;
  } rq_t;

  out_t out_q[$];
  rq_t  rq_q[$];
  int   errors = 0, checks = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: what MEM should receive and which request (if any)
  // the memory should see, from the instruction's architectural meaning.
  function automatic void model(input in_t t, input bit ext_cancel,
                                output out_t o, output bit has_rq, output rq_t r);
    logic [31:0] res, addr;
    logic [6:0]  ex;
    int nbytes, off;
    bit misaligned, issue;
    addr = t.a + t.b;
    case (t.op)
      3'd0: res = t.a + t.b;
      3'd1: res = t.a - t.b;
      3'd2: res = ($signed(t.a) < $signed(t.b)) ? 32'd1 : 32'd0;
      3'd3: res = (t.a < t.b) ? 32'd1 : 32'd0;
      3'd4: res = t.a & t.b;
      3'd5: res = t.a | t.b;
      3'd6: res = t.a ^ t.b;
      default: res = t.b;
    endcase
    if (t.mop[7] || t.mop[2])                   nbytes = 4;
    else if (t.mop[6] || t.mop[5] || t.mop[1])  nbytes = 2;
    else                                        nbytes = 1;
    misaligned = (t.mop != 0) && (nbytes > 1) && ((addr % nbytes) != 0);
    ex    = t.exc | (misaligned ? 7'h40 : 7'h00);
    issue = (t.mop != 0) && (ex == 0) && !ext_cancel;
    o.pc      = t.pc;
    o.collect = {(t.mop[7:3] != 0), t.we, t.wa, res};
    o.minst   = t.mop[7:3];
    o.bus     = {issue, ex};
    has_rq  = issue;
    off     = int'(addr[1:0]) / nbytes * nbytes;
    r.wr    = (t.mop[2:0] != 0);
    r.size  = (nbytes == 4) ? 2'd2 : (nbytes == 2) ? 2'd1 : 2'd0;
    r.wstrb = r.wr ? 4'(((1 << nbytes) - 1) << off) : 4'b0000;
    r.addr  = addr;
    r.wdata = (nbytes == 1) ? {4{t.sd[7:0]}} : (nbytes == 2) ? {2{t.sd[15:0]}} : t.sd;
  endfunction

  task automatic issue(input in_t t, input bit ext_cancel, input bit push);
    out_t o; rq_t r; bit hr; bit done;
    done = 1'b0;
    ds_to_es_valid = 1'b1; ds_pc = t.pc; ds_alu_op = t.op; ds_src1 = t.a;
    ds_src2 = t.b; ds_mem_op = t.mop; ds_st_data = t.sd; ds_rf_we = t.we;
    ds_rf_waddr = t.wa; ds_except = t.exc;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (es_allowin) begin
        done = 1'b1;
        if (push) begin
          model(t, ext_cancel, o, hr, r);
          out_q.push_back(o);
          if (hr) rq_q.push_back(r);
        end
      end
      @(posedge clk); #1;
    end
    ds_to_es_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got es_allowin=0 for 200 cycles expected 1");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic in_t mk(input logic [2:0] op, input logic [31:0] a, b,
                             input logic [7:0] mop, input logic [31:0] sd);
    in_t t;
    t.pc = 32'h1c00_0000 + a; t.op = op; t.a = a; t.b = b; t.mop = mop;
    t.sd = sd; t.we = 1'b1; t.wa = 5'd3; t.exc = 7'd0;
    return t;
  endfunction

  // Monitor: requests compared against the head of the request queue every
  // cycle they are presented (so held requests must stay stable).
  out_t mon_o;
  rq_t  mon_r;
  always @(negedge clk) begin
    if (mon_en && resetn) begin
      if (dmem.data_sram_req) begin
        if (rq_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: got req=1 addr=%h expected no request",
                   dmem.data_sram_addr);
        end else begin
          mon_r = rq_q[0];
          check("req_wr",    64'(dmem.data_sram_wr),    64'(mon_r.wr));
          check("req_size",  64'(dmem.data_sram_size),  64'(mon_r.size));
          check("req_wstrb", 64'(dmem.data_sram_wstrb), 64'(mon_r.wstrb));
          check("req_addr",  64'(dmem.data_sram_addr),  64'(mon_r.addr));
          if (mon_r.wr) check("req_wdata", 64'(dmem.data_sram_wdata), 64'(mon_r.wdata));
          if (dmem.data_sram_addr_ok) void'(rq_q.pop_front());
        end
      end
      if (es_to_ms_valid && ms_allowin) begin
        if (out_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out: got es_to_ms_valid=1 pc=%h expected none", es_pc);
        end else begin
          mon_o = out_q.pop_front();
          check("out_pc",      64'(es_pc),         64'(mon_o.pc));
          check("out_collect", 64'(es_rf_collect), 64'(mon_o.collect));
          check("out_minst",   64'(mem_inst_bus),  64'(mon_o.minst));
          check("out_bus",     64'(es_to_ms_bus),  64'(mon_o.bus));
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    rnd_addr_ok = ($urandom_range(0, 2) != 0);
    rnd_ms      = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t t;
    // Reset state
    resetn = 1'b0;
    #12;
    check("rst_allowin", 64'(es_allowin), 64'd1);
    check("rst_valid",   64'(es_to_ms_valid), 64'd0);
    check("rst_req",     64'(dmem.data_sram_req), 64'd0);
    check("rst_buses",   64'({es_rf_collect, es_to_ms_bus, mem_inst_bus}), 64'd0);
    check("rst_sram",    64'({dmem.data_sram_wstrb, dmem.data_sram_addr, dmem.data_sram_wr}), 64'd0);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // add 5+7, no memory op
    issue(mk(3'd0, 32'd5, 32'd7, 8'h00, 32'd0), 1'b0, 1'b1);
    check("add_valid_next", 64'(es_to_ms_valid), 64'd1);
    check("add_result",     64'(es_rf_collect[31:0]), 64'd12);
    check("add_wait",       64'(es_to_ms_bus[7]), 64'd0);
    idle(1);

    // st_b to 0x1003 with addr_ok held low for three cycles
    dir_addr_ok = 1'b0;
    issue(mk(3'd0, 32'h1000, 32'h3, 8'h01, 32'hAB), 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dir_addr_ok = 1'b1;
      @(negedge clk);
      check("stb_req_held", 64'(dmem.data_sram_req), 64'd1);
      check("stb_fields", {dmem.data_sram_addr, dmem.data_sram_wdata},
            {32'h1003, 32'hABAB_ABAB});
      check("stb_wstrb", 64'(dmem.data_sram_wstrb), 64'b1000);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("stb_req_done", 64'(dmem.data_sram_req), 64'd0);
    @(posedge clk); #1;

    // misaligned ld_h: no request, ALE raised
    issue(mk(3'd0, 32'h2000, 32'h1, 8'h40, 32'd0), 1'b0, 1'b1);
    @(negedge clk);
    check("ldh_no_req", 64'(dmem.data_sram_req), 64'd0);
    check("ldh_ale",    64'(es_to_ms_bus[6]), 64'd1);
    check("ldh_passes", 64'(es_to_ms_valid), 64'd1);
    @(posedge clk); #1;

    // st_w while WB holds an exception: cancelled, no request
    wb_ex = 1'b1;
    issue(mk(3'd0, 32'h3000, 32'h0, 8'h04, 32'h1234_5678), 1'b1, 1'b1);
    @(negedge clk);
    check("stw_wbex_no_req", 64'(dmem.data_sram_req), 64'd0);
    check("stw_wbex_passes", 64'(es_to_ms_valid), 64'd1);
    @(posedge clk); #1;
    wb_ex = 1'b0;

    // ld_w accepted by memory while MEM is stalled: SENT held, single request
    dir_ms = 1'b0;
    issue(mk(3'd0, 32'h3000, 32'h4, 8'h80, 32'd0), 1'b0, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("sent_no_req", 64'(dmem.data_sram_req), 64'd0);
      check("sent_valid",  64'(es_to_ms_valid), 64'd1);
      check("sent_wait",   64'(es_to_ms_bus[7]), 64'd1);
      @(posedge clk); #1;
    end
    dir_ms = 1'b1;
    idle(2);

    // except_flush while a request is held
    mon_en = 1'b0;
    dir_addr_ok = 1'b0;
    issue(mk(3'd0, 32'h4000, 32'h0, 8'h04, 32'hDEAD_BEEF), 1'b0, 1'b0);
    @(negedge clk);
    check("flush_pre_req", 64'(dmem.data_sram_req), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("flush_in_req", 64'(dmem.data_sram_req), 64'd1);
    @(posedge clk); #1;
    except_flush = 1'b1;
    @(posedge clk); #1;
    except_flush = 1'b0;
    @(negedge clk);
    check("flush_req_drop", 64'(dmem.data_sram_req), 64'd0);
    check("flush_no_valid", 64'(es_to_ms_valid), 64'd0);
    check("flush_allowin",  64'(es_allowin), 64'd1);
    dir_addr_ok = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("flush_idle_no_req", 64'(dmem.data_sram_req), 64'd0);
    @(posedge clk); #1;
    mon_en = 1'b1;

    // slt / sltu with -1 and 1
    issue(mk(3'd2, 32'hFFFF_FFFF, 32'd1, 8'h00, 32'd0), 1'b0, 1'b1);
    issue(mk(3'd3, 32'hFFFF_FFFF, 32'd1, 8'h00, 32'd0), 1'b0, 1'b1);
    idle(2);

    // Asynchronous reset while a request is held
    mon_en = 1'b0;
    dir_addr_ok = 1'b0;
    issue(mk(3'd0, 32'h5000, 32'h2, 8'h02, 32'h0000_CAFE), 1'b0, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_req_pre", 64'(dmem.data_sram_req), 64'd1);
    #2 resetn = 1'b0;
    #1;
    check("arst_req",     64'(dmem.data_sram_req), 64'd0);
    check("arst_valid",   64'(es_to_ms_valid), 64'd0);
    check("arst_allowin", 64'(es_allowin), 64'd1);
    check("arst_sram",    {dmem.data_sram_addr, dmem.data_sram_wdata}, 64'd0);
    check("arst_buses",   64'({es_rf_collect, es_to_ms_bus, dmem.data_sram_wstrb}), 64'd0);
    @(posedge clk); #1;
    @(negedge clk); resetn = 1'b1; dir_addr_ok = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_allowin", 64'(es_allowin), 64'd1);
    check("post_rst_no_req",  64'(dmem.data_sram_req), 64'd0);
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Random traffic with random addr_ok / ms_allowin back-pressure
    rnd_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 15);
      t.pc  = 32'h1c00_0000 + 32'(i) * 4;
      t.op  = 3'($urandom_range(0, 7));
      t.mop = (r < 8) ? (8'h01 << r) : 8'h00;
      t.a   = $urandom;
      t.b   = (t.mop != 0) ? 32'($urandom_range(0, 7)) : $urandom;
      t.sd  = $urandom;
      t.we  = 1'($urandom_range(0, 1));
      t.wa  = 5'($urandom_range(0, 31));
      t.exc = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(1, 63)) : 7'd0;
      issue(t, 1'b0, 1'b1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rnd_en = 1'b0;
    dir_ms = 1'b1; dir_addr_ok = 1'b1;
    for (int k = 0; k < 50 && (out_q.size() != 0 || rq_q.size() != 0); k++) idle(1);
    check("drain_out_q", 64'(out_q.size()), 64'd0);
    check("drain_rq_q",  64'(rq_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
